// File: rtl/mux_pkg.sv
// Shared constants for the N:1 handshake selector family.
package mux_pkg;

    // Selection modes for mux_nx1_hs.
    localparam int MODE_SEL = 0;  // externally steered by sel
    localparam int MODE_RR  = 1;  // round-robin among requesting inputs

    // Largest supported channel count.
    localparam int MAX_N = 16;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Starting just after ptr and wrapping
// modulo N, the first requesting channel wins. The pointer lives in the parent.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan channels ptr+1 .. ptr+N (mod N) and grant the first requester.
    always_comb begin
        // NOTE: every output and temporary gets a default before any
        // conditional assignment, so no path leaves a value held (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 1; off <= N; off++) begin
            idx = PTR_W'((int'(ptr) + off) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_nx1_hs.sv
// N-input, WIDTH-bit registered selector with valid/ready on every input and
// on the output. One cycle of latency, one word per cycle when the consumer
// keeps out_ready high. MODE_SEL steers with sel; MODE_RR arbitrates.
module mux_nx1_hs #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src
);

    import mux_pkg::*;

    logic             can_accept;
    logic             in_xfer;
    logic [N-1:0]     grant_sel;
    logic [N-1:0]     grant_rr;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] idx_rr;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] rr_ptr;

    // Round-robin candidate; disabled entirely in steered mode.
    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .en        (MODE == MODE_RR),
        .grant     (grant_rr),
        .grant_idx (idx_rr)
    );

    // Steered decode: an out-of-range sel (non power-of-2 N) grants nothing.
    always_comb begin
        grant_sel = '0;
        if ((int'(sel) < N) && in_valid[sel]) begin
            grant_sel[sel] = 1'b1;
        end
    end

    // Pick the grant source for the configured mode.
    always_comb begin
        if (MODE == MODE_RR) begin
            grant     = grant_rr;
            grant_idx = idx_rr;
        end else begin
            grant     = grant_sel;
            grant_idx = sel;
        end
    end

    // The register can take a word when empty or draining this cycle;
    // nothing is accepted while reset is held.
    always_comb begin
        can_accept = !rst && (!out_valid || out_ready);
        in_ready   = grant & {N{can_accept}};
        in_xfer    = |in_ready;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(N - 1);
        end else begin
            if (in_xfer) begin
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_src   <= grant_idx;
                out_valid <= 1'b1;
                if (MODE == MODE_RR) begin
                    rr_ptr <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : mux_nx1_hs

// File: tb/tb_mux_nx1_hs.sv
// Self-checking bench: three instances (steered N=4, round-robin N=4,
// steered N=3) driven together and compared against a behavioural model.
module tb_mux_nx1_hs;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus per instance (instance 2 uses channels 0..2 only).
    logic [W-1:0] ch [3][4];
    logic [3:0]   v  [3];
    logic [1:0]   s  [3];
    logic [2:0]   ordy;

    logic [4*W-1:0] d0_data, d1_data;
    logic [3*W-1:0] d2_data;
    assign d0_data = {ch[0][3], ch[0][2], ch[0][1], ch[0][0]};
    assign d1_data = {ch[1][3], ch[1][2], ch[1][1], ch[1][0]};
    assign d2_data = {ch[2][2], ch[2][1], ch[2][0]};

    logic [3:0]   r0, r1;
    logic [2:0]   r2;
    logic [W-1:0] od0, od1, od2;
    logic         ov0, ov1, ov2;
    logic [1:0]   os0, os1, os2;

    mux_nx1_hs #(.WIDTH(W), .N(4), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_data(d0_data), .in_valid(v[0]), .in_ready(r0),
        .sel(s[0]), .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]), .out_src(os0)
    );
    mux_nx1_hs #(.WIDTH(W), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(d1_data), .in_valid(v[1]), .in_ready(r1),
        .sel(s[1]), .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]), .out_src(os1)
    );
    mux_nx1_hs #(.WIDTH(W), .N(3), .MODE(0)) u_n3 (
        .clk(clk), .rst(rst), .in_data(d2_data), .in_valid(v[2][2:0]), .in_ready(r2),
        .sel(s[2]), .out_data(od2), .out_valid(ov2), .out_ready(ordy[2]), .out_src(os2)
    );

    logic [3:0]   obs_ready [3];
    logic [W-1:0] obs_data  [3];
    logic         obs_valid [3];
    logic [1:0]   obs_src   [3];
    always_comb begin
        obs_ready[0] = r0;  obs_ready[1] = r1;  obs_ready[2] = {1'b0, r2};
        obs_data[0]  = od0; obs_data[1]  = od1; obs_data[2]  = od2;
        obs_valid[0] = ov0; obs_valid[1] = ov1; obs_valid[2] = ov2;
        obs_src[0]   = os0; obs_src[1]   = os1; obs_src[2]   = os2;
    end

    // Reference model state.
    int           n_of    [3] = '{4, 4, 3};
    int           mode_of [3] = '{0, 1, 0};
    bit           m_valid [3];
    logic [W-1:0] m_data  [3];
    int           m_src   [3];
    int           m_ptr   [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_src[d]   = 0;
            m_ptr[d]   = n_of[d] - 1;
        end
    endfunction

    // Channel the rules award this cycle, or -1 for none.
    function automatic int exp_grant(input int d);
        int n;
        n = n_of[d];
        if (mode_of[d] == 0) begin
            if (int'(s[d]) < n && v[d][s[d]]) return int'(s[d]);
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (m_ptr[d] + k) % n;
            if (v[d][c]) return c;
        end
        return -1;
    endfunction

    // Called at a falling edge after inputs are set: checks the current
    // cycle, advances the model, and returns at the next falling edge.
    task automatic step();
        #1;
        for (int d = 0; d < 3; d++) begin
            int         g;
            bit         can;
            logic [3:0] exp_r;
            g     = exp_grant(d);
            can   = !m_valid[d] || ordy[d];
            exp_r = (g >= 0 && can) ? 4'(1 << g) : 4'b0;
            check($sformatf("d%0d_in_ready", d), 64'(obs_ready[d]), 64'(exp_r));
            check($sformatf("d%0d_out_valid", d), 64'(obs_valid[d]), 64'(m_valid[d]));
            check($sformatf("d%0d_out_data", d), 64'(obs_data[d]), 64'(m_data[d]));
            check($sformatf("d%0d_out_src", d), 64'(obs_src[d]), 64'(m_src[d]));
            if (exp_r != 0) begin
                m_valid[d] = 1'b1;
                m_data[d]  = ch[d][g];
                m_src[d]   = g;
                if (mode_of[d] == 1) m_ptr[d] = g;
            end else if (ordy[d]) begin
                m_valid[d] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            v[d] = '0;
            s[d] = '0;
            for (int c = 0; c < 4; c++) ch[d][c] = $urandom;
        end
        ordy = 3'b111;
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_d%0d_valid", tag, d), 64'(obs_valid[d]), 64'd0);
            check($sformatf("%s_d%0d_data", tag, d), 64'(obs_data[d]), 64'd0);
            check($sformatf("%s_d%0d_src", tag, d), 64'(obs_src[d]), 64'd0);
            check($sformatf("%s_d%0d_ready", tag, d), 64'(obs_ready[d]), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        model_reset();
        for (int d = 0; d < 3; d++) v[d] = 4'hF;  // in_ready must still be 0
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_all();

        // Steered load of channel 2.
        s[0] = 2'd2; v[0] = 4'b0100; ch[0][2] = 32'hDEADBEEF;
        step();
        check("sel_load_data", 64'(od0), 64'hDEADBEEF);
        check("sel_load_src",  64'(os0), 64'd2);
        check("sel_load_valid", 64'(ov0), 64'd1);

        // Backpressure: held word survives sel/data churn.
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s[0] = 2'($urandom); v[0] = 4'($urandom);
            for (int c = 0; c < 4; c++) ch[0][c] = $urandom;
            step();
            check("stall_hold_data", 64'(od0), 64'hDEADBEEF);
        end
        ordy[0] = 1'b1; s[0] = 2'd0; v[0] = 4'b0001; ch[0][0] = 32'h12345678;
        step();
        check("no_bubble_data",  64'(od0), 64'h12345678);
        check("no_bubble_valid", 64'(ov0), 64'd1);
        v[0] = '0;
        step();

        // Round-robin, all channels requesting.
        v[1] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 4; c++) ch[1][c] = $urandom;
            step();
            check("rr_seq_src",   64'(os1), 64'(i % 4));
            check("rr_seq_valid", 64'(ov1), 64'd1);
        end

        // Sparse requests after a grant to channel 0.
        v[1] = 4'b0001; step();
        v[1] = 4'b1001; step();
        check("rr_sparse_3", 64'(os1), 64'd3);
        step();
        check("rr_sparse_0", 64'(os1), 64'd0);
        v[1] = 4'b0000; step(); step();
        check("rr_idle_valid", 64'(ov1), 64'd0);
        v[1] = 4'b0011; step();
        check("rr_ptr_held", 64'(os1), 64'd1);
        v[1] = '0; step();

        // N=3 with an out-of-range select.
        v[2] = 4'b0111; s[2] = 2'd0; step();
        s[2] = 2'd3; step();
        step();
        check("n3_oor_ready", 64'(r2),  64'd0);
        check("n3_oor_valid", 64'(ov2), 64'd0);

        // Randomized traffic on all three instances.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                v[d]    = 4'($urandom);
                s[d]    = 2'($urandom);
                ordy[d] = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < 4; c++) ch[d][c] = $urandom;
            end
            step();
        end

        // Asynchronous reset during a stall.
        idle_all();
        s[0] = 2'd1; v[0] = 4'b0010; step();
        ordy[0] = 1'b0; v[0] = '0; v[1] = 4'hF; step();
        check("pre_reset_stall_valid", 64'(ov0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_all();
        v[1] = 4'hF;
        step();
        check("post_reset_rr_first", 64'(os1), 64'd0);
        v[1] = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_nx1_hs

// File: doc/mux_nx1_hs.md
Name: mux_nx1_hs

Overview:
- Parametrised N-input, WIDTH-bit registered selector with a valid/ready handshake on every input and on the output.
- Next generation of the ALU result/operand muxes: arbitrary input count and width.
- Two modes: externally steered selection, or round-robin arbitration among requesting inputs.
- Sits between producers (ALU, load unit, immediate path) and a single consumer such as the writeback stage. One cycle of latency, full throughput.

Parameters:
- WIDTH, 32, data width of each channel in bits.
- N, 4, number of input channels (2..16).
- MODE, 0, 0 = select-steered, 1 = round-robin arbitration (sel ignored).
- SEL_W, $clog2(N), derived localparam; width of sel and out_src.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit is high in any cycle.
- sel  input  SEL_W  channel select; used in MODE 0 only.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts.
- out_src  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset values (asynchronous, active-high): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1, so channel 0 has first priority. in_ready is combinational and therefore 0 during reset.
- can_accept = !out_valid || out_ready. Refill on the same cycle the output drains is allowed, giving one word per cycle.
- Grant, MODE 0:
  - grant = onehot(sel) when sel < N and in_valid[sel]; otherwise no grant.
  - sel >= N (possible only when N is not a power of 2) grants nothing and leaves the output unchanged. This replaces the zero-data default of the old mux.
- Grant, MODE 1:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo N; the first channel with in_valid high is granted.
- in_ready[i] = grant[i] && can_accept. Input transfer on channel g occurs when in_valid[g] && in_ready[g].
- On an input transfer: out_data <= channel g data, out_src <= g, out_valid <= 1. In MODE 1, rr_ptr <= g.
- Output transfer: out_valid && out_ready. If no input transfer occurs in the same cycle, out_valid <= 0. out_data and out_src hold their last values.
- Latency: input transfer at cycle t gives out_valid at t+1.
- Stall: while out_valid && !out_ready, out_data and out_src are held stable and all in_ready bits are 0.
- rr_ptr advances only on an input transfer, never on idle or stalled cycles. Wrap-around goes N-1 -> 0.
- sel changing while stalled has no effect on the held output word.
- Reset asserted mid-operation discards any held word. No partial state survives reset.
- Upstream contract: in_valid must not drop without a transfer. The block does not check this; it is a bench assertion only.

Decomposition:
- Shared package mux_pkg holds the MODE_SEL=0 and MODE_RR=1 constants and the max-N constant (16).
- One sub-module is natural: rr_arbiter. Parameter N. Inputs: req[N], ptr, en. Outputs: grant[N] one-hot, grant_idx. Purely combinational, with rr_ptr kept in the parent.
- The parent holds the output register, can_accept logic and MODE 0 decode.

Test Plan:
- MODE0, N=4, WIDTH=32: sel=2, in_valid=4'b0100, ch2=32'hDEADBEEF, out_ready=1. Expect out_data=DEADBEEF, out_src=2, out_valid=1 one cycle later, and in_ready=4'b0100 on the input cycle.
- Backpressure: after the load above, hold out_ready=0 for 3 cycles while changing sel and data. Expect out_data to stay DEADBEEF and in_ready=0. Release out_ready; the next word follows with no bubble.
- MODE1, all four valid continuously, out_ready=1. Expect out_src sequence 0,1,2,3,0,1 and one transfer per cycle.
- MODE1 sparse: in_valid=4'b1001 after a grant to 0. Expect the next grant to go to 3, then to 0. No grant when in_valid=0, and rr_ptr is unchanged.
- N=3, MODE0, sel=3 with all inputs valid. Expect in_ready=0 and out_valid to fall after a drain.
- Assert rst while out_valid=1 and a stall is in progress. Expect out_valid=0 and out_data=0 immediately (asynchronously). After release, the MODE1 first grant goes to channel 0.
